// File: rtl/mem_arbiter_if.sv
// Bundles the I/D requester, memory and fill-return signals of mem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int CNT_W = 3
);
  logic             i_req;
  logic [15:0]      i_addr;
  logic             d_req;
  logic             d_we;
  logic [15:0]      d_addr;
  logic [15:0]      d_wdata;
  logic             mem_en;
  logic             mem_wr;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_rvalid;
  logic [15:0]      fill_data;
  logic [CNT_W-1:0] fill_idx;
  logic             fill_i_valid;
  logic             fill_d_valid;
  logic             i_done;
  logic             d_done;
  logic             busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
           fill_i_valid, fill_d_valid, i_done, d_done, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
           fill_i_valid, fill_d_valid, i_done, d_done, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises I/D block fills and D write-throughs onto one pipelined memory; first mem_en one cycle after a request.
// No backpressure: one address issued per cycle, every mem_rvalid is taken; ARB_ROUND_ROBIN_EN alternates simultaneous grants.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int CNT_W           = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_e;

  localparam logic [15:0]      BLK_MASK = 16'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);

  state_e           state_q, state_d;
  logic [CNT_W:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [15:0]      base_q, base_d;
  logic             fill_st, issuing, ret_vld, last_ret;
  logic             grant_d, grant_i;
`ifdef ARB_ROUND_ROBIN_EN
  logic             rr_last_q, rr_last_d;
`endif

  // issue_cnt top bit set means all WORDS_PER_BLOCK addresses are out
  assign fill_st  = (state_q == I_FILL) || (state_q == D_FILL);
  assign issuing  = fill_st && !issue_cnt_q[CNT_W];
  assign ret_vld  = fill_st && bus.mem_rvalid;
  assign last_ret = ret_vld && (ret_cnt_q == LAST_IDX);

  always_comb begin
    grant_d = bus.d_req;
    grant_i = bus.i_req && !bus.d_req;
`ifdef ARB_ROUND_ROBIN_EN
    // rr_last_q: 0 = I granted last, 1 = D granted last
    if (bus.d_req && bus.i_req) begin
      grant_d = !rr_last_q;
      grant_i = rr_last_q;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    base_d      = base_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (grant_d) begin
          state_d = bus.d_we ? D_WRITE : D_FILL;
          if (!bus.d_we) base_d = bus.d_addr & ~BLK_MASK;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d = 1'b1;
`endif
        end else if (grant_i) begin
          state_d = I_FILL;
          base_d  = bus.i_addr & ~BLK_MASK;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d = 1'b0;
`endif
        end
      end
      I_FILL, D_FILL: begin
        if (issuing) issue_cnt_d = issue_cnt_q + 1'b1;
        if (last_ret) state_d = IDLE;
        else if (ret_vld) ret_cnt_d = ret_cnt_q + 1'b1;
      end
      D_WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en       = issuing || (state_q == D_WRITE);
    bus.mem_wr       = (state_q == D_WRITE);
    bus.mem_addr     = 16'h0000;
    bus.mem_wdata    = 16'h0000;
    bus.fill_data    = 16'h0000;
    bus.fill_idx     = '0;
    bus.fill_i_valid = ret_vld && (state_q == I_FILL);
    bus.fill_d_valid = ret_vld && (state_q == D_FILL);
    bus.i_done       = last_ret && (state_q == I_FILL);
    bus.d_done       = (last_ret && (state_q == D_FILL)) || (state_q == D_WRITE);
    bus.busy         = (state_q != IDLE);
    if (state_q == D_WRITE) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (issuing) begin
      bus.mem_addr = base_q + 16'({issue_cnt_q, 1'b0});
    end
    if (ret_vld) begin
      bus.fill_data = bus.mem_rdata;
      bus.fill_idx  = ret_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed 4-cycle read-latency memory model.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mem_arbiter_if #(.CNT_W(3)) bus ();

  mem_arbiter #(.WORDS_PER_BLOCK(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read issued in cycle c returns in cycle c+4, data = addr ^ 5A3C
  logic [3:0]  pipe_v;
  logic [15:0] pipe_d [4];
  logic        force_v;
  logic [15:0] force_dat;

  initial pipe_v = 4'b0000;
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[2:0], bus.mem_en && !bus.mem_wr};
    pipe_d[0] <= bus.mem_addr ^ 16'h5A3C;
    pipe_d[1] <= pipe_d[0];
    pipe_d[2] <= pipe_d[1];
    pipe_d[3] <= pipe_d[2];
  end

  assign bus.mem_rvalid = pipe_v[3] | force_v;
  assign bus.mem_rdata  = force_v ? force_dat : pipe_d[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Request already driven at start of cycle 0; returns at start of cycle 13 with req dropped
  task automatic run_fill(input bit side_i, input logic [15:0] base, input string tag);
    logic [15:0] ea;
    bit          en, vld;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      en  = (c >= 1) && (c <= 8);
      vld = (c >= 5) && (c <= 12);
      chk($sformatf("%s_en_c%0d", tag, c), 32'(bus.mem_en), 32'(en));
      chk($sformatf("%s_wr_c%0d", tag, c), 32'(bus.mem_wr), 0);
      chk($sformatf("%s_wdat_c%0d", tag, c), 32'(bus.mem_wdata), 0);
      if (en) begin
        ea = base + 16'(2 * (c - 1));
        chk($sformatf("%s_addr_c%0d", tag, c), 32'(bus.mem_addr), 32'(ea));
      end
      chk($sformatf("%s_ivld_c%0d", tag, c), 32'(bus.fill_i_valid), 32'(vld && side_i));
      chk($sformatf("%s_dvld_c%0d", tag, c), 32'(bus.fill_d_valid), 32'(vld && !side_i));
      if (vld) begin
        ea = (base + 16'(2 * (c - 5))) ^ 16'h5A3C;
        chk($sformatf("%s_idx_c%0d", tag, c), 32'(bus.fill_idx), 32'(c - 5));
        chk($sformatf("%s_data_c%0d", tag, c), 32'(bus.fill_data), 32'(ea));
      end
      chk($sformatf("%s_idone_c%0d", tag, c), 32'(bus.i_done), 32'((c == 12) && side_i));
      chk($sformatf("%s_ddone_c%0d", tag, c), 32'(bus.d_done), 32'((c == 12) && !side_i));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(bus.busy), 32'(c >= 1));
      next_cycle();
      if (c == 12) begin
        if (side_i) bus.i_req = 1'b0;
        else        bus.d_req = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_en"}, 32'(bus.mem_en), 0);
    chk({tag, "_ivld"}, 32'(bus.fill_i_valid), 0);
    chk({tag, "_dvld"}, 32'(bus.fill_d_valid), 0);
    chk({tag, "_idone"}, 32'(bus.i_done), 0);
    chk({tag, "_ddone"}, 32'(bus.d_done), 0);
  endtask

  task automatic d_write(input logic [15:0] a, input logic [15:0] w, input string tag);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = a;
    bus.d_wdata = w;
    idle_check({tag, "_c0"});
    next_cycle();
    @(negedge clk);
    chk({tag, "_en"}, 32'(bus.mem_en), 1);
    chk({tag, "_wr"}, 32'(bus.mem_wr), 1);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
    chk({tag, "_wdat"}, 32'(bus.mem_wdata), 32'(w));
    chk({tag, "_ddone"}, 32'(bus.d_done), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    next_cycle();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    idle_check({tag, "_c2"});
    chk({tag, "_c2_wdat"}, 32'(bus.mem_wdata), 0);
    next_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    force_v     = 1'b0;
    force_dat   = 16'h0000;
    bus.i_req   = 1'b0;
    bus.i_addr  = 16'h0000;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0000;
    bus.d_wdata = 16'h0000;
    repeat (3) next_cycle();
    rst_n = 1'b1;
    idle_check("rst");
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_data", 32'(bus.fill_data), 0);
    next_cycle();

    // I fill from 0x1236, then a 9th mem_rvalid after completion
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h1236;
    run_fill(1'b1, 16'h1230, "ifill");
    force_v   = 1'b1;
    force_dat = 16'hDEAD;
    idle_check("extra_rv");
    next_cycle();
    force_v = 1'b0;
    idle_check("after_extra");
    next_cycle();

    // Simultaneous pair: D wins (fixed priority, and RR with I last)
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0A5E;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h4008;
    run_fill(1'b0, 16'h4000, "pair1_d");
    run_fill(1'b1, 16'h0A50, "pair1_i");

    d_write(16'h0102, 16'hBEEF, "dwr");

    // Second pair right after a D grant
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h7770;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h3456;
`ifdef ARB_ROUND_ROBIN_EN
    run_fill(1'b1, 16'h7770, "pair2_i");
    run_fill(1'b0, 16'h3450, "pair2_d");
`else
    run_fill(1'b0, 16'h3450, "pair2_d");
    run_fill(1'b1, 16'h7770, "pair2_i");
`endif

    // Spurious returns while idle
    force_v   = 1'b1;
    force_dat = 16'h1111;
    idle_check("spur0");
    next_cycle();
    idle_check("spur1");
    next_cycle();
    force_v = 1'b0;

    // Reset in cycle 6 of an I fill; in-flight returns must be dropped
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h2222;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("abort_en_c%0d", c), 32'(bus.mem_en), 32'(c >= 1));
      next_cycle();
    end
    rst_n = 1'b0;
    next_cycle();
    rst_n     = 1'b1;
    bus.i_req = 1'b0;
    for (int c = 7; c <= 12; c++) begin
      idle_check($sformatf("abort_c%0d", c));
      next_cycle();
    end

    // Top-of-memory block: 0xFFF0..0xFFFE, restarting at word 0
    bus.i_req  = 1'b1;
    bus.i_addr = 16'hFFF4;
    run_fill(1'b1, 16'hFFF0, "wrap");
    idle_check("end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
